char_writer: RTL and testbench

CHAR_WRITER -- requirements
Module: char_writer

---
 rtl/char_writer.sv | 175 +++++++++++++++++
 tb/tb_char_writer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/char_writer.sv
// Character-cell text writer: turns a byte stream into writes on a COLS x ROWS
// character buffer, handling cursor motion, scroll-up on the last row and form-feed clear.
module char_writer #(
  parameter int COLS       = 80,
  parameter int ROWS       = 25,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            data,
  input  logic                  valid,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [7:0]            buf_din,
  output logic                  buf_write_en,
  input  logic [7:0]            buf_dout,
  output logic [6:0]            cursor_x,
  output logic [4:0]            cursor_y
);

  // Handshake: a byte moves when valid and ready are both high at a rising edge;
  // ready is high only in IDLE, and the sender holds data while ready is low.

  typedef enum logic [2:0] {
    IDLE, WRITE, SCROLL_RD, SCROLL_WR, SCROLL_FILL, CLEAR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_COPY  = ADDR_WIDTH'((ROWS - 1) * COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] FILL_BASE  = ADDR_WIDTH'((ROWS - 1) * COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(ROWS * COLS - 1);
  localparam logic [6:0]            LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0]            LAST_ROW   = 5'(ROWS - 1);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_n;
  logic [7:0]              din_q, din_n;
  logic [7:0]              code_q, code_n;
  logic                    we_q, we_n;
  logic                    copy_q, copy_n;
  logic [6:0]              x_q, x_n;
  logic [4:0]              y_q, y_n;
  logic [ADDR_WIDTH-1:0]   cur_addr;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  assign cur_addr = ADDR_WIDTH'(y_q) * ROW_STRIDE + ADDR_WIDTH'(x_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      idx_q  <= '0;
      din_q  <= '0;
      code_q <= '0;
      we_q   <= 1'b0;
      copy_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      idx_q  <= idx_n;
      din_q  <= din_n;
      code_q <= code_n;
      we_q   <= we_n;
      copy_q <= copy_n;
      x_q    <= x_n;
      y_q    <= y_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    idx_n   = idx_q;
    din_n   = din_q;
    code_n  = code_q;
    we_n    = 1'b0;
    copy_n  = 1'b0;
    x_n     = x_q;
    y_n     = y_q;
    case (state)
      IDLE: begin
        if (valid) begin
          code_n = data;
          if (is_printable(data)) begin
            state_n = WRITE;
            we_n    = 1'b1;
            addr_n  = cur_addr;
            din_n   = data;
          end else if (data == 8'h0A && y_q == LAST_ROW) begin
            state_n = SCROLL_RD;
            idx_n   = '0;
            addr_n  = ROW_STRIDE;
          end else if (data == 8'h0C) begin
            state_n = CLEAR;
            we_n    = 1'b1;
            addr_n  = '0;
            din_n   = 8'h20;
          end else begin
            // CR, LF, BS and ignored codes all spend one busy cycle in WRITE with no strobe
            state_n = WRITE;
          end
        end
      end
      WRITE: begin
        state_n = IDLE;
        if (is_printable(code_q)) begin
          if (x_q < LAST_COL) begin
            x_n = x_q + 7'd1;
          end else begin
            x_n = '0;
            if (y_q < LAST_ROW) begin
              y_n = y_q + 5'd1;
            end else begin
              state_n = SCROLL_RD;
              idx_n   = '0;
              addr_n  = ROW_STRIDE;
            end
          end
        end else if (code_q == 8'h0D) begin
          x_n = '0;
        end else if (code_q == 8'h0A) begin
          y_n = y_q + 5'd1;
        end else if (code_q == 8'h08 && x_q != 7'd0) begin
          x_n = x_q - 7'd1;
        end
      end
      SCROLL_RD: begin
        state_n = SCROLL_WR;
        addr_n  = idx_q;
        we_n    = 1'b1;
        copy_n  = 1'b1;
      end
      SCROLL_WR: begin
        if (idx_q == LAST_COPY) begin
          state_n = SCROLL_FILL;
          addr_n  = FILL_BASE;
          din_n   = 8'h20;
          we_n    = 1'b1;
        end else begin
          state_n = SCROLL_RD;
          idx_n   = idx_q + ADDR_WIDTH'(1);
          addr_n  = idx_q + ADDR_WIDTH'(1) + ROW_STRIDE;
        end
      end
      SCROLL_FILL, CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_n = IDLE;
          if (state == CLEAR) begin
            x_n = '0;
            y_n = '0;
          end
        end else begin
          addr_n = addr_q + ADDR_WIDTH'(1);
          we_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ready        = (state == IDLE);
  assign buf_addr     = addr_q;
  assign buf_write_en = we_q;
  // Read data only arrives in the SCROLL_WR cycle itself, so the copy path bypasses din_q.
  assign buf_din      = copy_q ? buf_dout : din_q;
  assign cursor_x     = x_q;
  assign cursor_y     = y_q;

endmodule

// File: tb/tb_char_writer.sv
// Bench for char_writer: screen model predicts every buffer write into a queue,
// a negedge monitor pops and compares each strobe, and cursor/busy counts are checked per byte.
module tb_char_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic [10:0] buf_addr;
  logic [7:0]  buf_din;
  logic        buf_write_en;
  logic [7:0]  buf_dout;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  logic [7:0]  mem [0:2047];
  logic        seed;
  logic [7:0]  model [0:1999];
  logic [18:0] exp_q [$];
  logic [18:0] mon_exp;
  int          mx, my;
  int          checks = 0;
  int          errors = 0;

  char_writer dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready),
    .buf_addr(buf_addr), .buf_din(buf_din), .buf_write_en(buf_write_en),
    .buf_dout(buf_dout), .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seed_byte(input int k);
    return 8'(8'h21 + (k % 90));
  endfunction

  // character buffer with one-cycle read latency
  always @(posedge clk) begin
    if (seed) begin
      for (int k = 0; k < 2048; k++) mem[k] <= seed_byte(k);
    end else if (buf_write_en) begin
      mem[buf_addr] <= buf_din;
    end
    buf_dout <= mem[buf_addr];
  end

  always @(negedge clk) begin
    if (buf_write_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d din %02h with nothing expected", buf_addr, buf_din);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({buf_addr, buf_din} !== mon_exp) begin
          errors++;
          $display("FAIL buf_write: got addr %0d din %02h, expected addr %0d din %02h",
                   buf_addr, buf_din, mon_exp[18:8], mon_exp[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_write(input int a, input logic [7:0] b);
    exp_q.push_back({11'(a), b});
    model[a] = b;
  endtask

  task automatic model_scroll();
    for (int i = 0; i < 1920; i++) push_write(i, model[i + 80]);
    for (int i = 1920; i < 2000; i++) push_write(i, 8'h20);
  endtask

  task automatic seed_all();
    @(negedge clk);
    seed = 1'b1;
    for (int k = 0; k < 2000; k++) model[k] = seed_byte(k);
    @(negedge clk);
    seed = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, output int eb);
    eb = 1;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_write(my * 80 + mx, b);
      if (mx < 79) mx++;
      else begin
        mx = 0;
        if (my < 24) my++;
        else begin model_scroll(); eb = 1 + 3920; end
      end
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h0A) begin
      if (my < 24) my++;
      else begin model_scroll(); eb = 3920; end
    end else if (b == 8'h08) begin
      if (mx > 0) mx--;
    end else if (b == 8'h0C) begin
      for (int k = 0; k < 2000; k++) push_write(k, 8'h20);
      mx = 0;
      my = 0;
      eb = 2000;
    end
  endtask

  task automatic send(input logic [7:0] b, input string name);
    int exp_busy;
    int busy;
    int guard;
    model_byte(b, exp_busy);
    @(negedge clk);
    data  = b;
    valid = 1'b1;
    guard = 0;
    while (!ready && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk);
    #1 valid = 1'b0;
    busy = 0;
    @(negedge clk);
    while (!ready && busy < 10000) begin busy++; @(negedge clk); end
    check({name, "_busy"}, busy, exp_busy);
    check({name, "_cursor_x"}, int'(cursor_x), mx);
    check({name, "_cursor_y"}, int'(cursor_y), my);
  endtask

  initial begin
    int guard;
    int bad;
    reset = 1'b1;
    valid = 1'b1;
    data  = 8'h42;
    seed  = 1'b0;
    mx = 0;
    my = 0;
    repeat (2) @(posedge clk);
    seed_all();
    check("rst_ready", int'(ready), 1);
    check("rst_we", int'(buf_write_en), 0);
    check("rst_addr", int'(buf_addr), 0);
    check("rst_din", int'(buf_din), 0);
    check("rst_cursor_x", int'(cursor_x), 0);
    check("rst_cursor_y", int'(cursor_y), 0);
    reset = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    check("post_rst_cursor_x", int'(cursor_x), 0);
    check("post_rst_ready", int'(ready), 1);

    send(8'h41, "char_A");
    send(8'h0C, "clear_1");
    for (int i = 0; i < 3; i++) send(8'h0A, "lf_down");
    for (int i = 0; i < 79; i++) send(8'(8'h61 + i % 26), "fill_row3");
    send(8'h5A, "char_Z_wrap");

    seed_all();
    for (int i = 0; i < 20; i++) send(8'h0A, "lf_to_bottom");
    for (int i = 0; i < 5; i++) send(8'h78, "col5");
    send(8'h0A, "lf_scroll");
    for (int i = 0; i < 74; i++) send(8'h79, "fill_bottom");
    send(8'h51, "wrap_scroll");

    send(8'h0C, "clear_2");
    for (int i = 0; i < 7; i++) send(8'h0A, "lf_row7");
    send(8'h08, "bs_col0");
    send(8'h0D, "cr_col0");
    send(8'h07, "bell_ignored");
    send(8'hFF, "ff_ignored");
    send(8'h61, "char_a");
    send(8'h62, "char_b");
    send(8'h08, "bs_back");
    send(8'h0D, "cr_home");

    // abort a clear once address 499 is being written
    seed_all();
    for (int k = 0; k < 500; k++) push_write(k, 8'h20);
    @(negedge clk);
    data  = 8'h0C;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!(buf_write_en && buf_addr == 11'd499) && guard < 3000) begin
      guard++;
      @(negedge clk);
    end
    check("clear_reached_499", int'(guard < 3000), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_we", int'(buf_write_en), 0);
    check("abort_cursor_x", int'(cursor_x), 0);
    check("abort_cursor_y", int'(cursor_y), 0);
    reset = 1'b0;
    mx = 0;
    my = 0;
    @(negedge clk);
    check("abort_ready", int'(ready), 1);
    bad = 0;
    for (int k = 0; k < 500; k++) if (mem[k] !== 8'h20) bad++;
    check("abort_cleared_part", bad, 0);
    bad = 0;
    for (int k = 500; k < 2000; k++) if (mem[k] !== seed_byte(k)) bad++;
    check("abort_untouched", bad, 0);
    repeat (3) @(negedge clk);
    check("pending_writes", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
